c499_resp_misr: RTL and testbench
=================================

# c499_resp_misr

Response compactor that sits directly downstream of the c499 wrapper and consumes its 32-bit `out_val` response word, one word per applied test pattern. Responses are folded into a multiple-input signature register (MISR) over a programmed number of patterns. The final signature is compared against a golden value, so a Trojan-induced deviation on any pattern shows up as a single pass/fail bit. A counter, a handshake and a three-state controller sequence each run.

## Interface
- `WIDTH`, 32, response word width; matches the wrapper output
- `CNT_W`, 16, pattern counter width
- `POLY`, 32'h04C11DB7, MISR feedback polynomial; bit i taps feedback into bit i
- `SEED`, 32'hFFFFFFFF, MISR value loaded at run start
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begins a run; sampled in IDLE and DONE only
- `num_patterns`  in  CNT_W  patterns per run, latched on start
- `golden`  in  WIDTH  expected signature, latched on start
- `resp_valid`  in  1  `resp_data` holds a valid response word
- `resp_data`  in  WIDTH  wrapper `out_val`
- `resp_ready`  out  1  block accepts a response this cycle
- `busy`  out  1  run in progress
- `done`  out  1  run finished; held until the next start or reset
- `pass`  out  1  signature equals golden; meaningful only while done=1
- `signature`  out  WIDTH  current MISR contents
- `pat_count`  out  CNT_W  responses accepted in the current run

## Operation
- The controller has three states: IDLE, RUN and DONE.
- **IDLE, start=1:**
  - Load sig=SEED and cnt=0; latch `num_patterns` and `golden`.
  - Go to DONE if num_patterns==0, otherwise go to RUN.
- **RUN:**
  - resp_ready=1 and busy=1.
  - Accept a word when resp_valid && resp_ready.
  - On accept: sig ← {sig[W-2:0],1'b0} ^ (sig[W-1] ? POLY : 0) ^ resp_data, and cnt ← cnt+1.
  - On the accept where cnt == num-1, go to DONE.
  - start is ignored in RUN.
  - resp_valid=0 stalls the run with no state change.
- **DONE:**
  - done=1; pass = (sig == golden latched).
  - start=1 begins a new run with the same load rules as IDLE.
  - Words presented here are not accepted (resp_ready=0).
- **Counter:** cnt never wraps, because the maximum num_patterns is 2^CNT_W−1.
- **Reset:**
  - Values: resp_ready=0, busy=0, done=0, pass=0, signature=SEED, pat_count=0, state IDLE.
  - Reset mid-run discards the run.
  - Simultaneous rst and start: rst wins.

## Timing
- State, sig and cnt are registered.
- resp_ready and busy decode from state only; there is no combinational path from resp_valid.
- The first accept can occur in the cycle after start is sampled.
- done, pass and the final signature are visible in the cycle after the last accept.
- With num_patterns==0, done rises in the cycle after start.
- Throughput is one response per cycle.
- golden and num_patterns changing during RUN have no effect.

## Configuration
- `C499_STUCK_DETECT_EN` defined:
  - Adds output `stuck_mask`  out  WIDTH.
  - The mask is cleared on start and on reset.
  - Bit i is set if response bit i never toggled across accepted words in the run, computed as ~(OR of (word_k ^ word_0)).
  - The mask is valid while done=1; on a single-pattern run it is all ones.
- Undefined: the port and its logic are absent; all other behaviour is identical.

## Structure
- Shared package `c499_test_pkg` holds:
  - `C499_MISR_POLY` and `C499_MISR_SEED` constants, used as parameter defaults;
  - the state enum `misr_state_t` {IDLE, RUN, DONE};
  - `C499_IN_W`=41 and `C499_OUT_W`=32.
- One sub-module, `misr_step`: a combinational next-signature function of (sig, data), parameterised by WIDTH and POLY, so it can be reused by a future upstream pattern generator.

## Test plan
- **Single zero pattern:** num=1, golden=32'hFB3EE249, one word 0.
  - Expect done one cycle after accept, signature=32'hFB3EE249, pass=1, pat_count=1.
- **Empty run:** num=0, golden=SEED.
  - Expect done in the cycle after start, pass=1, resp_ready never high.
- **Stalls:** num=4 with resp_valid toggled 1,0,0,1,1,0,1.
  - Expect exactly 4 accepts and a signature equal to the model's.
  - A flipped bit in word 3 gives pass=0.
- **Reset and start during RUN:** rst mid-run at cnt=2 returns IDLE with all reset values. start pulsed during RUN does not restart the run (pat_count keeps incrementing).
- **Restart from DONE:** start with num=2 and a new golden.
  - Expect sig reloaded to SEED, done drops in the cycle after start, and a new result.
- **`C499_STUCK_DETECT_EN` build:** words 0x1, 0x3, 0x1.
  - Expect stuck_mask=32'hFFFFFFFD.

Source files
------------

// File: rtl/c499_test_pkg.sv
// c499_test_pkg: shared constants and controller state type for the c499 test blocks
package c499_test_pkg;
  localparam logic [31:0] C499_MISR_POLY = 32'h04C11DB7;
  localparam logic [31:0] C499_MISR_SEED = 32'hFFFFFFFF;
  localparam int C499_IN_W = 41;
  localparam int C499_OUT_W = 32;
  typedef enum logic [1:0] {IDLE, RUN, DONE} misr_state_t;
endpackage

// File: rtl/misr_step.sv
// misr_step: combinational next-signature of a MISR folding one data word
module misr_step import c499_test_pkg::*; #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] POLY = C499_MISR_POLY
) (
  input  logic [WIDTH-1:0] sig,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] next
);
  assign next = {sig[WIDTH-2:0], 1'b0} ^ (sig[WIDTH-1] ? POLY : '0) ^ data;
endmodule

// File: rtl/c499_resp_misr.sv
// c499_resp_misr: MISR response compactor with golden compare; C499_STUCK_DETECT_EN adds stuck_mask
module c499_resp_misr import c499_test_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16,
  parameter logic [WIDTH-1:0] POLY = C499_MISR_POLY,
  parameter logic [WIDTH-1:0] SEED = C499_MISR_SEED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_patterns,
  input  logic [WIDTH-1:0] golden,
  input  logic             resp_valid,
  input  logic [WIDTH-1:0] resp_data,
  output logic             resp_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature,
  output logic [CNT_W-1:0] pat_count
`ifdef C499_STUCK_DETECT_EN
  ,
  output logic [WIDTH-1:0] stuck_mask
`endif
);
  misr_state_t state;
  logic [WIDTH-1:0] sig, gold, nxt;
  logic [CNT_W-1:0] cnt, num;
  logic load, acc;
  assign load = start && state != RUN;
  assign acc = state == RUN && resp_valid;
  misr_step #(.WIDTH(WIDTH), .POLY(POLY)) u_step (.sig(sig), .data(resp_data), .next(nxt));
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      sig <= SEED;
      cnt <= '0;
      num <= '0;
      gold <= '0;
    end else if (load) begin
      sig <= SEED;
      cnt <= '0;
      num <= num_patterns;
      gold <= golden;
      state <= num_patterns == '0 ? DONE : RUN;
    end else if (acc) begin
      sig <= nxt;
      cnt <= cnt + CNT_W'(1);
      if (cnt == num - CNT_W'(1)) state <= DONE;
    end
  assign resp_ready = state == RUN;
  assign busy = state == RUN;
  assign done = state == DONE;
  assign pass = done && sig == gold;
  assign signature = sig;
  assign pat_count = cnt;
`ifdef C499_STUCK_DETECT_EN
  // first word of the run is the reference; diff collects every bit that ever differed from it
  logic [WIDTH-1:0] w0, diff;
  always_ff @(posedge clk)
    if (rst || load) begin
      w0 <= '0;
      diff <= '0;
    end else if (acc) begin
      if (cnt == '0) w0 <= resp_data;
      else diff <= diff | (resp_data ^ w0);
    end
  assign stuck_mask = ~diff;
`endif
endmodule

// File: tb/tb_c499_resp_misr.sv
// tb_c499_resp_misr: randomized scoreboard bench for the MISR response compactor
module tb_c499_resp_misr;
  localparam logic [31:0] POLY = 32'h04C11DB7;
  localparam logic [31:0] SEED = 32'hFFFFFFFF;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, resp_valid = 1'b0;
  logic [15:0] num_patterns = '0;
  logic [31:0] golden = '0, resp_data = '0;
  logic resp_ready, busy, done, pass;
  logic [31:0] signature;
  logic [15:0] pat_count;
`ifdef C499_STUCK_DETECT_EN
  logic [31:0] stuck_mask;
`endif
  int checks = 0, errors = 0, acc_cnt = 0;
  logic done_prev = 1'b0;
  typedef struct {logic [31:0] sig; logic pass; logic [15:0] cnt; logic [31:0] mask;} exp_t;
  exp_t q[$];
  logic [31:0] words[$];

  c499_resp_misr dut (
    .clk(clk), .rst(rst), .start(start), .num_patterns(num_patterns), .golden(golden),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_ready(resp_ready), .busy(busy),
    .done(done), .pass(pass), .signature(signature), .pat_count(pat_count)
`ifdef C499_STUCK_DETECT_EN
    , .stuck_mask(stuck_mask)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, a, e);
    end
  endtask

  // signature as polynomial arithmetic: multiply by x modulo POLY, then add the word
  function automatic logic [31:0] model_sig(input logic [31:0] w[$]);
    logic [32:0] s;
    s = {1'b0, SEED};
    foreach (w[i]) begin
      s = s << 1;
      if (s[32]) s = s ^ {1'b1, POLY};
      s[31:0] = s[31:0] ^ w[i];
    end
    return s[31:0];
  endfunction

  function automatic logic [31:0] model_mask(input logic [31:0] w[$]);
    logic [31:0] m;
    m = '1;
    foreach (w[i]) m = m & ~(w[i] ^ w[0]);
    return m;
  endfunction

  task automatic chk_reset();
    chk("rst_ready", resp_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_sig", signature, SEED);
    chk("rst_cnt", pat_count, 0);
  endtask

  // accepts are counted from pre-edge values so the monitor never races the driver
  always @(posedge clk)
    if (rst || (start && !busy)) acc_cnt <= 0;
    else if (resp_valid && resp_ready) acc_cnt <= acc_cnt + 1;

  always @(negedge clk) begin
    exp_t e;
    if (rst) q.delete();
    else if (done && !done_prev) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done got done=1 expected no run pending");
      end else begin
        e = q.pop_front();
        chk("sig", signature, e.sig);
        chk("pass", pass, e.pass);
        chk("pat_count", pat_count, e.cnt);
        chk("accepts", acc_cnt, e.cnt);
`ifdef C499_STUCK_DETECT_EN
        if (e.cnt != 0) chk("stuck_mask", stuck_mask, e.mask);
`endif
      end
    end
    done_prev = done;
  end

  // mode 0: always valid, 1: fixed 1,0,0,1,1,0,1 pattern, 2: random stalls
  task automatic do_run(input logic [31:0] gold, input int mode, input bit poke);
    int n, k, cyc;
    bit acc;
    bit [6:0] pat;
    exp_t e;
    n = words.size();
    k = 0;
    cyc = 0;
    pat = 7'b1011001;
    e.sig = model_sig(words);
    e.pass = e.sig == gold;
    e.cnt = 16'(n);
    e.mask = model_mask(words);
    q.push_back(e);
    @(negedge clk);
    start = 1;
    num_patterns = 16'(n);
    golden = gold;
    @(negedge clk);
    start = 0;
    num_patterns = 16'($urandom);
    golden = $urandom;
    if (n == 0) begin
      chk("empty_done", done, 1);
      chk("empty_ready", resp_ready, 0);
      @(negedge clk);
      chk("empty_ready_hold", resp_ready, 0);
      return;
    end
    chk("start_busy", busy, 1);
    chk("start_done_low", done, 0);
    chk("start_seed", signature, SEED);
    while (k < n && cyc < 200) begin
      resp_valid = mode == 0 ? 1'b1 : mode == 1 ? (cyc < 7 ? pat[cyc] : 1'b1) : 1'($urandom_range(0, 1));
      resp_data = words[k];
      start = poke && k == 2;
      num_patterns = 16'd1;
      acc = resp_valid && resp_ready;
      @(negedge clk);
      if (acc) k++;
      cyc++;
    end
    resp_valid = 0;
    start = 0;
    if (k < n) chk("accept_timeout", k, n);
    chk("done_timing", done, 1);
  endtask

  initial begin
    logic [31:0] g;
    int n;
    repeat (3) @(negedge clk);
    chk_reset();
    rst = 0;
    @(negedge clk);
    chk_reset();
    words = {};
    do_run(SEED, 0, 0);
    chk("empty_pass", pass, 1);
    words = {32'h0};
    do_run(32'hFB3EE249, 0, 0);
    chk("zero_sig", signature, 32'hFB3EE249);
    chk("zero_pass", pass, 1);
    chk("zero_cnt", pat_count, 1);
    words = {};
    repeat (4) words.push_back($urandom);
    g = model_sig(words);
    do_run(g, 1, 0);
    chk("stall_pass", pass, 1);
    words[3] = words[3] ^ (32'h1 << $urandom_range(0, 31));
    do_run(g, 1, 0);
    chk("flip_pass", pass, 0);
    words = {};
    repeat (5) words.push_back($urandom);
    do_run(model_sig(words), 0, 1);
    chk("poke_cnt", pat_count, 5);
    chk("poke_pass", pass, 1);
    words = {$urandom, $urandom};
    do_run($urandom, 0, 0);
    repeat (8) begin
      n = $urandom_range(1, 12);
      words = {};
      repeat (n) words.push_back($urandom_range(0, 1) ? $urandom : $urandom & 32'h0000_00F3);
      do_run($urandom_range(0, 1) ? model_sig(words) : $urandom, 2, 0);
    end
    words = {32'h1, 32'h3, 32'h1};
    do_run(model_sig(words), 0, 0);
`ifdef C499_STUCK_DETECT_EN
    chk("stuck_direct", stuck_mask, 32'hFFFFFFFD);
`endif
    @(negedge clk);
    start = 1;
    num_patterns = 16'd6;
    golden = '0;
    @(negedge clk);
    start = 0;
    resp_valid = 1;
    resp_data = $urandom;
    n = 0;
    while (pat_count != 16'd2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mid_cnt", pat_count, 2);
    rst = 1;
    resp_valid = 0;
    @(negedge clk);
    rst = 0;
    chk_reset();
    @(negedge clk);
    chk_reset();
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
